bsg_round_robin_arb_packet: RTL
===============================

BSG_ROUND_ROBIN_ARB_PACKET -- requirements
Module: bsg_round_robin_arb_packet

Interface
REQ-001 Parameter inputs_p, default 8: number of requesters; legal range 2..128.
REQ-002 Parameter max_beats_p, default 16: maximum beats per locked packet; legal range 1..65535.
REQ-003 Port clk_i, input, 1: the single clock; all state updates on its rising edge.
REQ-004 Port reset_n_i, input, 1: synchronous, active-low reset.
REQ-005 Port reqs_i, input, inputs_p: per-requester request, bit i = requester i.
REQ-006 Port last_i, input, 1: the current beat of the granted requester is the last beat of its packet.
REQ-007 Port grants_en_i, input, 1: when 0, forces grants_o to all zeros.
REQ-008 Port grants_o, output, inputs_p: one-hot grant vector, or all zeros.
REQ-009 Port tag_o, output, clog2(inputs_p): index of the selected requester.
REQ-010 Port v_o, output, 1: a selected requester is presenting a beat.
REQ-011 Port yumi_i, input, 1: the consumer accepts the current beat this cycle.
REQ-012 Port locked_o, output, 1: high while in state BUSY.

Function
REQ-013 The block SHALL have two states: IDLE (arbitrating) and BUSY (locked to one requester).
REQ-014 Registers: last_r (index of the last requester served), tag_r (locked index), beat_cnt_r (width clog2(max_beats_p+1)).
REQ-015 In IDLE, selection SHALL be combinational: pick the first set reqs_i bit scanning from index last_r+1 upward, wrapping modulo inputs_p, ending at last_r.
REQ-016 In IDLE: v_o = OR of reqs_i; tag_o = selected index; grants_o = one-hot(selected) AND grants_en_i.
REQ-017 In IDLE, when v_o=0: tag_o=0 and grants_o=0.
REQ-018 In IDLE, the selection MAY change from cycle to cycle until a beat is accepted.
REQ-019 IDLE, yumi_i=1, last_i=1: stay IDLE; last_r <= selected index.
REQ-020 IDLE, yumi_i=1, last_i=0, max_beats_p>1: go to BUSY; tag_r <= selected index; beat_cnt_r <= 1.
REQ-021 IDLE, yumi_i=1, max_beats_p=1: treat as last_i=1 (stay IDLE, update last_r).
REQ-022 In BUSY: tag_o = tag_r; v_o = reqs_i[tag_r]; grants_o = one-hot(tag_r) AND v_o AND grants_en_i; requests from other indices are ignored.
REQ-023 BUSY, yumi_i=1, last_i=0: beat_cnt_r increments.
REQ-024 BUSY, yumi_i=1 with last_i=1 OR beat_cnt_r+1 == max_beats_p: go to IDLE (forced release on the beat limit); last_r <= tag_r; beat_cnt_r <= 0.
REQ-025 BUSY with reqs_i[tag_r]=0: v_o=0; stay BUSY and wait for the requester; no timeout on idle cycles.
REQ-026 yumi_i while v_o=0 SHALL be ignored (no state change) and flagged by a simulation assertion.
REQ-027 yumi_i while grants_en_i=0 SHALL be ignored and flagged by the same assertion.
REQ-028 Outputs SHALL depend combinationally on reqs_i, grants_en_i and state only, never on yumi_i or last_i.
REQ-029 Zero-cycle latency: request to v_o in the same cycle.
REQ-030 Priority rotation SHALL guarantee each continuously requesting index is granted within inputs_p packets.

Reset
REQ-031 reset_n_i=0 at a clock edge SHALL set: state=IDLE, last_r=inputs_p-1 (index 0 has first priority), tag_r=0, beat_cnt_r=0.
REQ-032 Reset asserted during BUSY SHALL abandon the packet with no release beat required.
REQ-033 While reset_n_i=0, outputs follow the IDLE equations from the reset state values.

Verification (inputs_p=8, max_beats_p=4)
REQ-034 After reset, reqs_i=0x81, yumi_i=1, last_i=1 for 2 cycles -> tag_o=0 then 7; grants_o=0x01 then 0x80.
REQ-035 reqs_i=0xFF, yumi_i=1 with last_i=1 every cycle for 9 cycles -> tag_o sequence 0,1,...,7,0.
REQ-036 Requester 2 sends a 3-beat packet (last_i on beat 3) while reqs_i=0x0C throughout -> tag_o=2 for 3 accepted beats, locked_o=1 for beats 2-3, then tag_o=3.
REQ-037 Requester 1 holds last_i=0 for 6 beats -> forced release after beat 4; locked_o drops; next grant to the next requester, or back to 1 if it is alone.
REQ-038 In BUSY on index 5, drop reqs_i[5] for 3 cycles with reqs_i[6]=1 -> v_o=0 and grants_o=0 during the gap; lock kept; index 5 resumes when its request returns.
REQ-039 Assert reset_n_i=0 mid-packet -> next cycle locked_o=0, last_r=7; with grants_en_i=0, grants_o=0 while v_o still tracks reqs_i.

Source files
------------

// File: rtl/bsg_round_robin_arb_packet_if.sv
// Handshake bundle between a set of packet requesters, the round-robin
// packet arbiter and the downstream consumer of the granted beats.
interface bsg_round_robin_arb_packet_if #(
    parameter int inputs_p = 8
);
    localparam int tag_w = $clog2(inputs_p);

    logic [inputs_p-1:0] reqs_i;
    logic                last_i;
    logic                grants_en_i;
    logic                yumi_i;
    logic [inputs_p-1:0] grants_o;
    logic [tag_w-1:0]    tag_o;
    logic                v_o;
    logic                locked_o;

    modport master (
        output reqs_i, last_i, grants_en_i, yumi_i,
        input  grants_o, tag_o, v_o, locked_o
    );

    modport slave (
        input  reqs_i, last_i, grants_en_i, yumi_i,
        output grants_o, tag_o, v_o, locked_o
    );
endinterface

// File: rtl/bsg_round_robin_arb_packet.sv
// Round-robin arbiter that locks onto one requester for a whole packet.
// In IDLE the winner is chosen combinationally, scanning upward from the
// requester after the one served last. Accepting a non-final beat locks the
// arbiter (BUSY) onto that requester until it sends its last beat or hits
// max_beats_p beats, after which priority rotates past it.
module bsg_round_robin_arb_packet #(
    parameter int inputs_p    = 8,
    parameter int max_beats_p = 16
) (
    input logic                          clk_i,
    input logic                          reset_n_i,
    bsg_round_robin_arb_packet_if.slave  io
);
    localparam int tag_w = $clog2(inputs_p);
    localparam int cnt_w = $clog2(max_beats_p + 1);

    localparam logic [0:0] state_idle = 1'b0;
    localparam logic [0:0] state_busy = 1'b1;

    localparam logic [tag_w-1:0] last_reset = tag_w'(inputs_p - 1);
    localparam logic [cnt_w:0]   beat_limit = (cnt_w + 1)'(max_beats_p);

    logic [0:0]       state_r;
    logic [tag_w-1:0] last_r;
    logic [tag_w-1:0] tag_r;
    logic [cnt_w-1:0] beat_cnt_r;

    logic [0:0]       state_eff;
    logic [tag_w-1:0] last_eff;
    logic             sel_found;
    logic [tag_w-1:0] sel_idx;
    logic [tag_w-1:0] scan_idx;
    logic [tag_w-1:0] out_tag;
    logic             out_v;
    logic             accept;
    logic [cnt_w:0]   beat_next;
    logic             release_beat;

    // While reset is held the outputs behave as if the registers already hold their reset values
    assign state_eff = reset_n_i ? state_r : state_idle;
    assign last_eff  = reset_n_i ? last_r  : last_reset;

    // Rotating priority scan: first requester after last_eff, wrapping around, ending at last_eff
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        scan_idx  = '0;
        for (int i = 1; i <= inputs_p; i++) begin
            scan_idx = tag_w'((int'(last_eff) + i) % inputs_p);
            if (!sel_found && io.reqs_i[scan_idx]) begin
                sel_found = 1'b1;
                sel_idx   = scan_idx;
            end
        end
    end

    // Output selection: free arbitration in IDLE, pinned to the locked requester in BUSY
    always_comb begin
        out_v       = 1'b0;
        out_tag     = '0;
        io.grants_o = '0;
        if (state_eff == state_busy) begin
            out_tag = tag_r;
            out_v   = io.reqs_i[tag_r];
        end else begin
            out_tag = sel_idx;
            out_v   = sel_found;
        end
        if (out_v && io.grants_en_i) begin
            io.grants_o[out_tag] = 1'b1;
        end
    end

    assign io.v_o      = out_v;
    assign io.tag_o    = out_tag;
    assign io.locked_o = (state_eff == state_busy);

    assign accept       = io.yumi_i && out_v && io.grants_en_i;
    assign beat_next    = {1'b0, beat_cnt_r} + (cnt_w + 1)'(1);
    assign release_beat = io.last_i || (beat_next == beat_limit);

    // Packet lock state machine, advanced only by beats the consumer actually accepts
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_r    <= state_idle;
            last_r     <= last_reset;
            tag_r      <= '0;
            beat_cnt_r <= '0;
        end else if (accept) begin
            if (state_r == state_idle) begin
                if (io.last_i || (max_beats_p == 1)) begin
                    last_r <= sel_idx;
                end else begin
                    state_r    <= state_busy;
                    tag_r      <= sel_idx;
                    beat_cnt_r <= cnt_w'(1);
                end
            end else if (release_beat) begin
                state_r    <= state_idle;
                last_r     <= tag_r;
                beat_cnt_r <= '0;
            end else begin
                beat_cnt_r <= beat_next[cnt_w-1:0];
            end
        end
    end

    // A consumer accept with nothing valid or grants disabled is a protocol error upstream
    a_yumi_legal: assert property (@(posedge clk_i) disable iff (!reset_n_i)
                                   io.yumi_i |-> (out_v && io.grants_en_i));

endmodule
